// File: rtl/xalu.sv
// xalu: multi-cycle HI/LO multiply/divide unit. The result is computed at launch and held pending.
// A down-counter supplies the latency, and the result commits to HI/LO when the counter expires.
module xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pend_op_q, pend_op_d;
  logic [63:0]   pend_res_q, pend_res_d;
  logic          pend_wr_q, pend_wr_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  // Behavioural arithmetic on the launch operands
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, divu_b, sq_u, sr_u, uq, ur;
  logic [63:0] launch_res;
  logic        launch_ok;

  always_comb begin
    prod_u = {32'b0, A} * {32'b0, B};
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    abs_a  = A[31] ? (~A + 32'd1) : A;
    abs_b  = B[31] ? (~B + 32'd1) : B;
    // Divider is forced nonzero so the datapath never sees x/0; the result is discarded anyway.
    divu_b = (B == 32'd0) ? 32'd1 : B;
    uq     = A / divu_b;
    ur     = A % divu_b;
    sq_u   = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
    sr_u   = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
  end

  always_comb begin
    launch_res = 64'd0;
    launch_ok  = 1'b1;
    case (op)
      OP_MULT:  launch_res = prod_s;
      OP_MADD:  launch_res = prod_s;
      OP_MULTU: launch_res = prod_u;
      OP_DIV: begin
        // Magnitude divide then re-sign; 0x80000000 / -1 wraps back to 0x80000000.
        launch_res[31:0]  = (A[31] ^ B[31]) ? (~sq_u + 32'd1) : sq_u;
        launch_res[63:32] = A[31] ? (~sr_u + 32'd1) : sr_u;
        launch_ok         = (B != 32'd0);
      end
      OP_DIVU: begin
        launch_res = {ur, uq};
        launch_ok  = (B != 32'd0);
      end
      default: launch_res = 64'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_op_d  = pend_op_q;
    pend_res_d = pend_res_q;
    pend_wr_d  = pend_wr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_DIV, OP_DIVU: begin
              state_d    = BUSY;
              cnt_d      = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              pend_op_d  = op;
              pend_res_d = launch_res;
              pend_wr_d  = launch_ok;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            if (pend_op_q == OP_MADD)
              {hi_d, lo_d} = {hi_q, lo_q} + pend_res_q;
            else
              {hi_d, lo_d} = pend_res_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_op_q  <= 3'd0;
      pend_res_q <= 64'd0;
      pend_wr_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_op_q  <= pend_op_d;
      pend_res_q <= pend_res_d;
      pend_wr_q  <= pend_wr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Directed self-checking bench for xalu; inputs change on falling edges, outputs sampled there too.
module tb_xalu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  xalu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge (first cycle after the launch edge).
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", LO); end
  endtask

  // Start coincides with reset release: the first rising edge with reset low takes it.
  task automatic test_mult;
    reset = 1'b0;
    launch(3'd1, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < MC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy cyc %0d got %0b want 1", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done got %0b want 0", busy); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", LO); end
  endtask

  task automatic test_div_signed;
    launch(3'd3, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < DC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy cyc %0d got %0b want 1", i + 1, busy); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_early_lo cyc %0d got %h want fffffffa", i + 1, LO); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_done got %0b want 0", busy); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
  endtask

  task automatic test_divu_zero;
    launch(3'd4, 32'd7, 32'd0);
    for (int i = 0; i < DC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divz_busy cyc %0d got %0b want 1", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_done got %0b want 0", busy); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL divz_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_hi got %h want ffffffff", HI); end
  endtask

  task automatic test_div_overflow;
    launch(3'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (DC) @(negedge clk);
    checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", LO); end
    checks++; if (HI !== 32'h00000000) begin errors++; $display("FAIL divovf_hi got %h want 00000000", HI); end
  endtask

  task automatic test_div_misc;
    launch(3'd3, 32'd7, 32'hFFFFFFFE);
    repeat (DC) @(negedge clk);
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL divneg_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL divneg_hi got %h want 00000001", HI); end
    launch(3'd4, 32'hFFFFFFFF, 32'd2);
    repeat (DC) @(negedge clk);
    checks++; if (LO !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu_lo got %h want 7fffffff", LO); end
    checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL divu_hi got %h want 00000001", HI); end
  endtask

  task automatic test_op_none;
    launch(3'd0, 32'h55555555, 32'h3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL opnone_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL opnone_hi got %h want 00000001", HI); end
    checks++; if (LO !== 32'h7FFFFFFF) begin errors++; $display("FAIL opnone_lo got %h want 7fffffff", LO); end
  endtask

  task automatic test_mthi_mtlo_madd;
    launch(3'd6, 32'd0, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mthi_hi got %h want 00000000", HI); end
    launch(3'd7, 32'hFFFFFFFF, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %0b want 0", busy); end
    checks++; if (LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL mtlo_lo got %h want ffffffff", LO); end
    launch(3'd5, 32'd1, 32'd1);
    for (int i = 0; i < MC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL madd_busy cyc %0d got %0b want 1", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL madd_hi got %h want 00000001", HI); end
    checks++; if (LO !== 32'h00000000) begin errors++; $display("FAIL madd_lo got %h want 00000000", LO); end
    // Negative product: {1,0} + (-1) = {0,ffffffff}
    launch(3'd5, 32'hFFFFFFFF, 32'd1);
    repeat (MC) @(negedge clk);
    checks++; if (HI !== 32'h00000000) begin errors++; $display("FAIL maddneg_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL maddneg_lo got %h want ffffffff", LO); end
  endtask

  task automatic test_reset_mid;
    launch(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h want 00000000", LO); end
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstpost_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstpost_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rstpost_lo got %h want 00000000", LO); end
  endtask

  task automatic test_start_while_busy;
    launch(3'd1, 32'd3, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_busy1 got %0b want 1", busy); end
    @(negedge clk);
    start = 1'b1; op = 3'd7; A = 32'hDEADBEEF;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_busy2 got %0b want 1", busy); end
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = 32'd0;
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL swb_lo_mid got %h want 00000000", LO); end
    for (int i = 2; i < MC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_busy cyc %0d got %0b want 1", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_done got %0b want 0", busy); end
    checks++; if (LO !== 32'd12) begin errors++; $display("FAIL swb_lo got %h want 0000000c", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL swb_hi got %h want 00000000", HI); end
  endtask

  // Each launch issues in the first idle cycle after the previous completion.
  task automatic test_back_to_back;
    launch(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < MC; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy cyc %0d got %0b want 1", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", HI); end
    checks++; if (LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", LO); end
    launch(3'd6, 32'h12345678, 32'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL b2b_hi got %h want 12345678", HI); end
    checks++; if (LO !== 32'h00000001) begin errors++; $display("FAIL b2b_lo got %h want 00000001", LO); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div_signed;
    test_divu_zero;
    test_div_overflow;
    test_div_misc;
    test_op_none;
    test_mthi_mtlo_madd;
    test_reset_mid;
    test_start_while_busy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
